// File: rtl/pea_pkg.sv
// Shared types and widths for the PE array.
// Holds the divider-arbiter state encoding.
package pea_pkg;

    localparam int N_BITS = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } div_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Search starts at ptr_i and wraps; reusable for any shared FU.
module rr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int LOG_N_REQ = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]     req_i,
    input  logic [LOG_N_REQ-1:0] ptr_i,
    output logic [N_REQ-1:0]     gnt_o,
    output logic [LOG_N_REQ-1:0] idx_o,
    output logic                 any_o
);

    // First requester at or after ptr_i, modulo N_REQ
    always_comb begin
        int   j;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr_i) + k) % N_REQ;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = LOG_N_REQ'(j);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/s_div_arbiter.sv
// Shares one iterative divider between N_REQ PEs.
// Round-robin grant, one operation in flight, result to owner only.
module s_div_arbiter
    import pea_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int N_BITS    = pea_pkg::N_BITS,
    parameter int LOG_N_REQ = $clog2(N_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          flush_i,
    input  logic [N_REQ-1:0]              req_valid_i,
    output logic [N_REQ-1:0]              req_ready_o,
    input  logic [N_REQ-1:0][N_BITS-1:0]  req_a_i,
    input  logic [N_REQ-1:0][N_BITS-1:0]  req_b_i,
    input  logic [N_REQ-1:0]              req_rem_i,
    output logic [N_REQ-1:0]              rsp_valid_o,
    input  logic [N_REQ-1:0]              rsp_ready_i,
    output logic [N_BITS-1:0]             rsp_data_o,
    output logic                          div_valid_o,
    input  logic                          div_ready_i,
    output logic [N_BITS-1:0]             div_a_o,
    output logic [N_BITS-1:0]             div_b_o,
    input  logic                          div_valid_i,
    input  logic [N_BITS-1:0]             div_quot_i,
    input  logic [N_BITS-1:0]             div_rem_i,
    output logic [LOG_N_REQ-1:0]          grant_o,
    output logic                          busy_o,
    output logic                          err_o
);

    div_arb_state_t         state_q;
    logic [N_BITS-1:0]      a_q;
    logic [N_BITS-1:0]      b_q;
    logic [N_BITS-1:0]      data_q;
    logic                   rem_q;
    logic                   div_valid_q;
    logic                   busy_q;
    logic                   err_q;
    logic                   pend_q;
    logic [N_REQ-1:0]       rsp_valid_q;
    logic [LOG_N_REQ-1:0]   grant_q;
    logic [LOG_N_REQ-1:0]   rr_ptr_q;

    logic [LOG_N_REQ-1:0]   grant_inc;
    logic [N_REQ-1:0]       grant_oh;
    logic [N_REQ-1:0]       arb_gnt;
    logic [LOG_N_REQ-1:0]   arb_idx;
    logic                   arb_any;
    logic                   inflight;

    rr_arbiter #(
        .N_REQ     (N_REQ),
        .LOG_N_REQ (LOG_N_REQ)
    ) u_rr_arbiter (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Accept is only offered while idle and not being flushed
    assign req_ready_o = (state_q == IDLE && !flush_i) ? arb_gnt : '0;

    assign grant_inc = (grant_q == LOG_N_REQ'(N_REQ - 1)) ?
                       '0 : grant_q + LOG_N_REQ'(1);

    // A divider op is outstanding once the operand handshake happened
    assign inflight = (state_q == WAIT) ||
                      (state_q == ISSUE && div_ready_i);

    // One-hot form of the current owner
    always_comb begin
        grant_oh          = '0;
        grant_oh[grant_q] = 1'b1;
    end

    // Control FSM with operand/result, pointer and error registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            data_q      <= '0;
            rem_q       <= 1'b0;
            div_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            pend_q      <= 1'b0;
            rsp_valid_q <= '0;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
        end else begin
            // Stale result of a flushed op is swallowed, anything else
            // arriving outside WAIT is a protocol error
            if (div_valid_i && pend_q) begin
                pend_q <= 1'b0;
            end else if (div_valid_i && state_q != WAIT) begin
                err_q <= 1'b1;
            end

            if (flush_i) begin
                state_q     <= IDLE;
                div_valid_q <= 1'b0;
                rsp_valid_q <= '0;
                busy_q      <= 1'b0;
                if (inflight &&
                    !(state_q == WAIT && div_valid_i && !pend_q)) begin
                    pend_q <= 1'b1;
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (arb_any) begin
                            grant_q     <= arb_idx;
                            a_q         <= req_a_i[arb_idx];
                            b_q         <= req_b_i[arb_idx];
                            rem_q       <= req_rem_i[arb_idx];
                            div_valid_q <= 1'b1;
                            busy_q      <= 1'b1;
                            state_q     <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (div_ready_i) begin
                            div_valid_q <= 1'b0;
                            state_q     <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (div_valid_i && !pend_q) begin
                            data_q      <= rem_q ? div_rem_i : div_quot_i;
                            rsp_valid_q <= grant_oh;
                            state_q     <= RESP;
                        end
                    end
                    RESP: begin
                        if (rsp_ready_i[grant_q]) begin
                            rsp_valid_q <= '0;
                            rr_ptr_q    <= grant_inc;
                            busy_q      <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = data_q;
    assign div_valid_o = div_valid_q;
    assign div_a_o     = a_q;
    assign div_b_o     = b_q;
    assign grant_o     = grant_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

endmodule
